// File: rtl/uart_cnt_pkg.sv
// Shared encodings for the UART-controlled counter: command bytes, report framing
// and the state encodings of the control and report FSMs.
package uart_cnt_pkg;

    localparam logic [7:0] CMD_RUN    = 8'h72;  // 'r' toggle run
    localparam logic [7:0] CMD_STOP   = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLEAR  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_QUERY  = 8'h71;  // 'q'

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    // Index of the final byte of a report: 4 digits, CR, LF.
    localparam logic [2:0] REPORT_LAST_IDX = 3'd5;

    typedef enum logic [1:0] {
        CTRL_STOP  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_CLEAR = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_SEND = 2'd1,
        RPT_WAIT = 2'd2
    } rpt_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_RUN) || (b == CMD_STOP) || (b == CMD_CLEAR) || (b == CMD_QUERY);
    endfunction

    function automatic logic [7:0] report_byte(input logic [15:0] bcd, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
            3'd1:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
            3'd2:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
            3'd3:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
            3'd4:    b = CHAR_CR;
            default: b = CHAR_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cnt_ctrl_if.sv
// Byte-level link between the counter controller and its UART receiver/transmitter.
// master = controller side, slave = UART side.
interface uart_cnt_ctrl_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_tx_busy;
    logic [7:0] o_tx_data;
    logic       o_tx_start;

    modport master (input  i_rx_data, i_rx_valid, i_tx_busy, output o_tx_data, o_tx_start);
    modport slave  (output i_rx_data, i_rx_valid, i_tx_busy, input  o_tx_data, o_tx_start);
endinterface

// File: rtl/uart_cnt_ctrl_report_tx_seq.sv
// Report sequencer: snapshots the BCD count on start and streams four ASCII digits,
// CR and LF to the UART transmitter, one start pulse per byte.
module report_tx_seq
    import uart_cnt_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] count_bcd,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        idle
);

    rpt_state_t  state, state_nxt;
    logic [15:0] snap, snap_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        first, first_nxt;

    // NOTE: clocked processes use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RPT_IDLE;
            snap  <= '0;
            idx   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            snap  <= snap_nxt;
            idx   <= idx_nxt;
            first <= first_nxt;
        end
    end

    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        idx_nxt   = idx;
        first_nxt = first;
        tx_start  = 1'b0;
        case (state)
            RPT_IDLE: begin
                if (start) begin
                    snap_nxt  = count_bcd;
                    idx_nxt   = '0;
                    state_nxt = RPT_SEND;
                end
            end
            RPT_SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    first_nxt = 1'b1;
                    state_nxt = RPT_WAIT;
                end
            end
            RPT_WAIT: begin
                // Busy may lag the start pulse by a cycle, so the first WAIT cycle is blind.
                if (first) begin
                    first_nxt = 1'b0;
                end else if (!tx_busy) begin
                    if (idx == REPORT_LAST_IDX) begin
                        state_nxt = RPT_IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = RPT_SEND;
                    end
                end
            end
            default: state_nxt = RPT_IDLE;
        endcase
    end

    assign tx_data = tx_start ? report_byte(snap, idx) : 8'h00;
    assign idle    = (state == RPT_IDLE);

endmodule

// File: rtl/uart_cnt_ctrl.sv
// Counter controller: arbitrates buttons against UART commands (with a one-byte
// pending slot), runs the STOP/RUN/CLEAR control FSM and launches status reports.
module uart_cnt_ctrl
    import uart_cnt_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   btn_run,
    input  logic                   btn_clr,
    input  logic [15:0]            i_count_bcd,
    uart_cnt_ctrl_if.master        uart,
    output logic                   o_run_on,
    output logic                   o_clr_on,
    output logic                   o_err
);

    ctrl_state_t state, state_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [7:0]  pend_byte, pend_byte_nxt;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        btn_evt, rx_ok, rx_bad, drop, cmd_err;
    logic        q_req, rpt_idle, rpt_start, err_nxt;
    logic        tx_start;
    logic [7:0]  tx_data;

    assign btn_evt = btn_run | btn_clr;
    assign rx_ok   = uart.i_rx_valid &  is_cmd(uart.i_rx_data);
    assign rx_bad  = uart.i_rx_valid & ~is_cmd(uart.i_rx_data);

    // Buttons win the cycle; a colliding command waits one slot, a second one is dropped.
    always_comb begin
        cmd_valid      = 1'b0;
        cmd            = pend_byte;
        pend_valid_nxt = pend_valid;
        pend_byte_nxt  = pend_byte;
        drop           = 1'b0;
        if (btn_evt) begin
            if (rx_ok) begin
                if (pend_valid) begin
                    drop = 1'b1;
                end else begin
                    pend_valid_nxt = 1'b1;
                    pend_byte_nxt  = uart.i_rx_data;
                end
            end
        end else if (pend_valid) begin
            cmd_valid      = 1'b1;
            pend_valid_nxt = 1'b0;
            drop           = rx_ok;
        end else if (rx_ok) begin
            cmd_valid = 1'b1;
            cmd       = uart.i_rx_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_err   = 1'b0;
        case (state)
            CTRL_STOP: begin
                if (btn_run)                                state_nxt = CTRL_RUN;
                else if (btn_clr)                           state_nxt = CTRL_CLEAR;
                else if (cmd_valid && cmd == CMD_RUN)       state_nxt = CTRL_RUN;
                else if (cmd_valid && cmd == CMD_CLEAR)     state_nxt = CTRL_CLEAR;
            end
            CTRL_RUN: begin
                if (btn_run) begin
                    state_nxt = CTRL_STOP;
                end else if (cmd_valid) begin
                    if (cmd == CMD_RUN || cmd == CMD_STOP)  state_nxt = CTRL_STOP;
                    else if (cmd == CMD_CLEAR)              cmd_err   = 1'b1;
                end
            end
            CTRL_CLEAR: begin
                if (!btn_clr)                               state_nxt = CTRL_STOP;
                if (cmd_valid && cmd != CMD_QUERY)          cmd_err   = 1'b1;
            end
            default: state_nxt = CTRL_STOP;
        endcase
    end

    assign q_req     = cmd_valid && (cmd == CMD_QUERY);
    assign rpt_start = q_req && rpt_idle;
    assign err_nxt   = rx_bad | drop | cmd_err | (q_req & ~rpt_idle);

    // NOTE: the pending data byte is reset along with its valid flag so reset leaves no stale command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CTRL_STOP;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            o_run_on   <= 1'b0;
            o_clr_on   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_valid <= pend_valid_nxt;
            pend_byte  <= pend_byte_nxt;
            o_run_on   <= (state_nxt == CTRL_RUN);
            o_clr_on   <= (state_nxt == CTRL_CLEAR);
            o_err      <= err_nxt;
        end
    end

    report_tx_seq u_report (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (rpt_start),
        .count_bcd (i_count_bcd),
        .tx_busy   (uart.i_tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .idle      (rpt_idle)
    );

    assign uart.o_tx_start = tx_start;
    assign uart.o_tx_data  = tx_data;

endmodule

// File: tb/tb_uart_cnt_ctrl.sv
// Self-checking bench for uart_cnt_ctrl: directed scenarios followed by random
// buttons/bytes, all compared against a behavioural model with a byte scoreboard.
module tb_uart_cnt_ctrl;

    localparam logic [7:0] C_R = 8'h72, C_S = 8'h73, C_C = 8'h63, C_Q = 8'h71;

    typedef enum {M_STOP, M_RUN, M_CLEAR} mode_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_run, btn_clr;
    logic [15:0] i_count_bcd;
    logic        o_run_on, o_clr_on, o_err;

    uart_cnt_ctrl_if uart();

    uart_cnt_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_run     (btn_run),
        .btn_clr     (btn_clr),
        .i_count_bcd (i_count_bcd),
        .uart        (uart),
        .o_run_on    (o_run_on),
        .o_clr_on    (o_clr_on),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Model state
    mode_t       m_mode;
    logic        m_err;
    logic [7:0]  m_pend[$];
    logic [7:0]  exp_bytes[$];
    int          busy_left, busy_len, quiet, starts_seen;
    logic        start_pending;
    logic [15:0] cnt_drive;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic known_cmd(input logic [7:0] b);
        return (b == C_R) || (b == C_S) || (b == C_C) || (b == C_Q);
    endfunction

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // Behavioural rules: buttons first, one-deep deferral, command effects per mode.
    task automatic model_step(input logic br, input logic bc, input logic rv, input logic [7:0] rd);
        logic       ok, has_ex;
        logic [7:0] ex;
        mode_t      old;
        ok     = rv && known_cmd(rd);
        has_ex = 1'b0;
        ex     = 8'h00;
        old    = m_mode;
        m_err  = rv && !known_cmd(rd);
        if (br || bc) begin
            if (ok) begin
                if (m_pend.size() != 0) m_err = 1'b1;
                else                    m_pend.push_back(rd);
            end
        end else if (m_pend.size() != 0) begin
            ex = m_pend.pop_front();
            has_ex = 1'b1;
            if (ok) m_err = 1'b1;
        end else if (ok) begin
            ex = rd;
            has_ex = 1'b1;
        end
        case (old)
            M_STOP:  if (br) m_mode = M_RUN; else if (bc) m_mode = M_CLEAR;
            M_RUN:   if (br) m_mode = M_STOP;
            default: if (!bc) m_mode = M_STOP;
        endcase
        if (has_ex) begin
            if (ex == C_Q) begin
                if (exp_bytes.size() != 0) begin
                    m_err = 1'b1;
                end else begin
                    for (int k = 3; k >= 0; k--)
                        exp_bytes.push_back(8'h30 + 8'((i_count_bcd >> (4 * k)) & 16'h000F));
                    exp_bytes.push_back(8'h0D);
                    exp_bytes.push_back(8'h0A);
                end
            end else if (old == M_CLEAR) begin
                m_err = 1'b1;
            end else if (ex == C_C) begin
                if (old == M_STOP) m_mode = M_CLEAR;
                else               m_err  = 1'b1;
            end else if (ex == C_S) begin
                m_mode = M_STOP;
            end else begin
                m_mode = (old == M_RUN) ? M_STOP : M_RUN;
            end
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, observe tx, advance model.
    task automatic cycle(input logic br, input logic bc, input logic rv, input logic [7:0] rd);
        @(negedge clk);
        check("run_on", o_run_on, m_mode == M_RUN);
        check("clr_on", o_clr_on, m_mode == M_CLEAR);
        check("err",    o_err,    m_err);
        if (start_pending) begin
            busy_left     = busy_len;
            start_pending = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        uart.i_tx_busy = (busy_left > 0);
        if (exp_bytes.size() == 0 && busy_left == 0) quiet++;
        else                                          quiet = 0;
        btn_run         = br;
        btn_clr         = bc;
        uart.i_rx_valid = rv;
        uart.i_rx_data  = rd;
        i_count_bcd     = cnt_drive;
        #1;
        if (uart.o_tx_start) begin
            if (exp_bytes.size() == 0) check("tx_extra", uart.o_tx_start, 1'b0);
            else                       check("tx_data", uart.o_tx_data, exp_bytes.pop_front());
            start_pending = 1'b1;
            starts_seen++;
        end
        model_step(br, bc, rv, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_report_done(input string tag);
        for (int k = 0; k < 500 && !(exp_bytes.size() == 0 && quiet >= 3); k++) idle(1);
        check(tag, exp_bytes.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        reset_n         = 1'b0;
        btn_run         = 1'b0;
        btn_clr         = 1'b0;
        uart.i_rx_valid = 1'b0;
        uart.i_rx_data  = 8'h00;
        uart.i_tx_busy  = 1'b0;
        m_mode = M_STOP;
        m_err  = 1'b0;
        m_pend.delete();
        exp_bytes.delete();
        busy_left     = 0;
        start_pending = 1'b0;
        quiet         = 100;
        #1;
        check({tag, "_run_on"},   o_run_on,        1'b0);
        check({tag, "_clr_on"},   o_clr_on,        1'b0);
        check({tag, "_err"},      o_err,           1'b0);
        check({tag, "_tx_start"}, uart.o_tx_start, 1'b0);
        check({tag, "_tx_data"},  uart.o_tx_data,  8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int   s0, cnt;
        logic br, bc_lvl, rv;
        logic [7:0] rd;

        reset_n     = 1'b1;
        starts_seen = 0;
        busy_len    = 10;
        cnt_drive   = 16'h0000;
        i_count_bcd = 16'h0000;
        #3;
        do_reset("rst");

        // 'r' starts the counter one cycle later, 's' stops it
        cycle(1'b0, 1'b0, 1'b1, C_R);
        check("r_not_yet", o_run_on, 1'b0);
        idle(1);
        check("r_run_on", o_run_on, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, C_S);
        idle(1);
        check("s_run_off", o_run_on, 1'b0);

        // Button beats a simultaneous 's', which then executes a cycle later
        cycle(1'b1, 1'b0, 1'b1, C_S);
        idle(1);
        check("btn_pri_run", o_run_on, 1'b1);
        idle(1);
        check("pend_stop", o_run_on, 1'b0);

        // 'c' is refused in RUN; held clear button gives a matching clear window
        cycle(1'b0, 1'b0, 1'b1, C_R);
        cycle(1'b0, 1'b0, 1'b1, C_C);
        idle(1);
        check("c_in_run_err", o_err, 1'b1);
        check("c_in_run_noclr", o_clr_on, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, C_S);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, i < 5, 1'b0, 8'h00);
            cnt += int'(o_clr_on);
        end
        check("clr_len", cnt, 5);
        check("clr_to_stop", o_clr_on, 1'b0);

        // Query report with a slow transmitter
        busy_len  = 10;
        cnt_drive = 16'h0427;
        s0 = starts_seen;
        cycle(1'b0, 1'b0, 1'b1, C_Q);
        idle(1);
        check("q_first_start", starts_seen - s0, 1);
        cnt_drive = 16'h9999;
        wait_report_done("rpt_done");
        check("rpt_bytes", starts_seen - s0, 6);

        // Query during a report and an unknown byte are both refused
        s0 = starts_seen;
        cycle(1'b0, 1'b0, 1'b1, C_Q);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, C_Q);
        idle(1);
        check("q_busy_err", o_err, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h41);
        idle(1);
        check("bad_byte_err", o_err, 1'b1);
        wait_report_done("rpt2_done");
        check("rpt_only6", starts_seen - s0, 6);

        // Reset after the third report byte aborts the report
        cycle(1'b0, 1'b0, 1'b1, C_R);
        s0 = starts_seen;
        cycle(1'b0, 1'b0, 1'b1, C_Q);
        for (int k = 0; k < 200 && (starts_seen - s0) < 3; k++) idle(1);
        check("third_byte", starts_seen - s0, 3);
        idle(1);
        do_reset("mid");
        s0 = starts_seen;
        idle(60);
        check("no_tx_after_rst", starts_seen - s0, 0);

        // Random buttons, bytes, counts and transmitter speeds
        bc_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            busy_len  = $urandom_range(1, 6);
            cnt_drive = rand_bcd();
            br = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) bc_lvl = ~bc_lvl;
            rv = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       rd = C_R;
                1:       rd = C_S;
                2:       rd = C_C;
                3, 4:    rd = C_Q;
                default: rd = 8'($urandom_range(0, 255));
            endcase
            // Queries only where report activity is unambiguous to the model
            if (rv && rd == C_Q &&
                (br || bc_lvl || m_pend.size() != 0 || !(exp_bytes.size() >= 2 || quiet >= 3)))
                rv = 1'b0;
            cycle(br, bc_lvl, rv, rd);
        end
        wait_report_done("drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cnt_ctrl.md
UART_CNT_CTRL -- requirements
Module: uart_cnt_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 btn_run  in  1  debounced run/stop button, one-cycle pulse per press.
REQ-005 btn_clr  in  1  debounced clear button, level.
REQ-006 i_rx_data  in  8  received UART byte, valid only when i_rx_valid=1.
REQ-007 i_rx_valid  in  1  one-cycle strobe per received byte.
REQ-008 i_count_bcd  in  16  counter value as 4 BCD digits, [15:12] most significant.
REQ-009 i_tx_busy  in  1  UART transmitter busy; rises at most 1 cycle after o_tx_start.
REQ-010 o_run_on  out  1  counter enable.
REQ-011 o_clr_on  out  1  counter synchronous clear.
REQ-012 o_tx_data  out  8  byte to transmit, valid with o_tx_start.
REQ-013 o_tx_start  out  1  one-cycle transmit request.
REQ-014 o_err  out  1  one-cycle pulse on rejected command.

Function
REQ-015 Commands SHALL be 'r' 8'h72 toggle run, 's' 8'h73 stop, 'c' 8'h63 clear, 'q' 8'h71 query; any other byte with i_rx_valid SHALL pulse o_err the following cycle.
REQ-016 Control FSM SHALL have states STOP, RUN, CLEAR; o_run_on=1 only in RUN, o_clr_on=1 only in CLEAR, both registered from state.
REQ-017 STOP->RUN on btn_run or 'r'; STOP->CLEAR on btn_clr=1 or 'c'; otherwise hold.
REQ-018 RUN->STOP on btn_run, 'r' or 's'; 'c' or btn_clr in RUN SHALL be ignored and 'c' SHALL pulse o_err.
REQ-019 CLEAR SHALL hold while btn_clr=1 and for a minimum of one cycle; then CLEAR->STOP; UART commands in CLEAR except 'q' SHALL pulse o_err.
REQ-020 Buttons SHALL have priority over UART: a rx byte arriving in the same cycle as a button event SHALL be held in a 1-entry pending register and executed the next cycle.
REQ-021 A second rx byte arriving while pending is occupied SHALL be dropped with o_err.
REQ-022 'q' SHALL snapshot i_count_bcd in the acceptance cycle and transmit 6 bytes: 4 ASCII digits (8'h30+digit, MSD first), 8'h0D, 8'h0A.
REQ-023 Report FSM SHALL have states IDLE, SEND, WAIT; SEND pulses o_tx_start only when i_tx_busy=0; WAIT ignores i_tx_busy in its first cycle, then returns to SEND (next byte) or IDLE (after byte 6) when i_tx_busy=0.
REQ-024 'q' accepted while report FSM not IDLE SHALL be rejected with o_err; the running report continues.
REQ-025 Control and report FSMs SHALL operate concurrently; 'q' SHALL not change control state.
REQ-026 Latency: button or UART command to o_run_on/o_clr_on change SHALL be exactly 1 cycle (2 if deferred per REQ-020); 'q' to first o_tx_start 1 cycle when i_tx_busy=0.

Reset
REQ-027 On reset_n=0 all state SHALL clear asynchronously: control STOP, report IDLE, pending empty, o_run_on=0, o_clr_on=0, o_tx_start=0, o_tx_data=8'h00, o_err=0.
REQ-028 Reset mid-report SHALL abort the report; no further bytes after reset_n rises until a new 'q'.

Structure
REQ-029 Command byte codes, CR/LF codes and both FSM state encodings SHALL live in a shared package uart_cnt_pkg.
REQ-030 Report sequencing (REQ-022..024) SHALL be a sub-module report_tx_seq; the top holds arbitration and control FSM.

Verification
REQ-031 Reset, rx 'r' -> o_run_on=1 one cycle later; rx 's' -> o_run_on=0.
REQ-032 btn_run and rx 's' same cycle in STOP -> RUN next cycle, then STOP the cycle after.
REQ-033 In RUN rx 'c' -> o_err pulse, o_clr_on stays 0; in STOP btn_clr high 5 cycles -> o_clr_on=1 for 5 cycles, then STOP.
REQ-034 i_count_bcd=16'h0427, rx 'q', tx model busy 10 cycles/byte -> bytes 30,34,32,37,0D,0A in order, one start per byte.
REQ-035 Second 'q' during report -> o_err pulse, only 6 bytes total; rx 8'h41 -> o_err.
REQ-036 reset_n low after 3rd report byte -> all outputs at reset values, no further o_tx_start.
